// File: rtl/spi_slave_ctrl.sv
// SPI slave controller: oversamples SPI pins in the iclk domain, deserialises MOSI into an
// RX FIFO write port and serialises TX FIFO bytes onto MISO through a one-entry prefetch.
module spi_slave_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  icontrol_cpol,
  input  logic                  icontrol_cpha,
  input  logic                  icontrol_lsb,
  input  logic                  iclear_flags,
  input  logic                  itx_valid,
  output logic                  otx_req,
  input  logic [DATA_WIDTH-1:0] itx_data,
  input  logic                  itx_resp,
  output logic                  otx_ack,
  output logic                  orx_req,
  output logic [DATA_WIDTH-1:0] orx_data,
  input  logic                  irx_ack,
  input  logic                  spi_clk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic                  obusy,
  output logic                  ooverrun,
  output logic                  ounderrun
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StateIdle, StateLoad, StateShift, StatePush} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic [SYNC_STAGES:0]   flush_q;

  // Edges are ignored until the synchroniser has been refilled from the pins after reset
  always_ff @(posedge iclk) begin
    if (irst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      flush_q     <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic sclk_s, cs_s, mosi_s, armed;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic cpol_q, cpha_q, lsb_q;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign armed       = flush_q[SYNC_STAGES];
  assign sclk_rise   = armed & sclk_s & ~sclk_dly_q;
  assign sclk_fall   = armed & ~sclk_s & sclk_dly_q;
  assign cs_fall     = armed & ~cs_s & cs_dly_q;
  assign cs_rise     = armed & cs_s & ~cs_dly_q;
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  state_e                state_q, state_d;
  logic                  cpol_d, cpha_d, lsb_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, load_word;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  miso_q, miso_d, oe_q, oe_d, busy_q, busy_d;
  logic                  orx_req_q, orx_req_d, ovr_q, ovr_d, und_q, und_d;
  logic [DATA_WIDTH-1:0] orx_data_q, orx_data_d, hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d, hold_take;
  logic                  otx_req_q, otx_req_d, otx_ack_q, otx_ack_d;

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q      <= StateIdle;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      lsb_q        <= 1'b0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      cnt_q        <= '0;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      busy_q       <= 1'b0;
      orx_req_q    <= 1'b0;
      orx_data_q   <= '0;
      ovr_q        <= 1'b0;
      und_q        <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      otx_req_q    <= 1'b0;
      otx_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      lsb_q        <= lsb_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      cnt_q        <= cnt_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      busy_q       <= busy_d;
      orx_req_q    <= orx_req_d;
      orx_data_q   <= orx_data_d;
      ovr_q        <= ovr_d;
      und_q        <= und_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      otx_req_q    <= otx_req_d;
      otx_ack_q    <= otx_ack_d;
    end
  end

  // SPI frame FSM; orx_req clearing and flag clearing run regardless of state
  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    cnt_d      = cnt_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    busy_d     = ~cs_s;
    orx_req_d  = orx_req_q & ~irx_ack;
    orx_data_d = orx_data_q;
    ovr_d      = ovr_q & ~iclear_flags;
    und_d      = und_q & ~iclear_flags;
    hold_take  = 1'b0;
    load_word  = hold_valid_q ? hold_q : '0;
    case (state_q)
      StateIdle: begin
        oe_d = 1'b0;
        if (cs_fall) begin
          cpol_d  = icontrol_cpol;
          cpha_d  = icontrol_cpha;
          lsb_d   = icontrol_lsb;
          state_d = StateLoad;
        end
      end
      StateLoad: begin
        hold_take = hold_valid_q;
        if (!hold_valid_q) und_d = 1'b1;
        cnt_d   = '0;
        oe_d    = 1'b1;
        tx_sh_d = load_word;
        if (!cpha_q) begin
          miso_d  = lsb_q ? load_word[0] : load_word[DATA_WIDTH-1];
          tx_sh_d = lsb_q ? (load_word >> 1) : (load_word << 1);
        end
        state_d = StateShift;
      end
      StateShift: begin
        if (sample_edge) begin
          rx_sh_d = lsb_q ? {mosi_s, rx_sh_q[DATA_WIDTH-1:1]}
                          : {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_WIDTH - 1)) state_d = StatePush;
        end
        // With cpha=0 the first bit went out at load, so the trailing edge that closes
        // the previous frame must not advance the new one
        if (shift_edge && (cpha_q || cnt_q != '0)) begin
          miso_d  = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1];
          tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
        end
      end
      StatePush: begin
        if (!orx_req_q) begin
          orx_data_d = rx_sh_q;
          orx_req_d  = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
        state_d = StateLoad;
      end
      default: state_d = StateIdle;
    endcase
    if (cs_rise) begin
      state_d = StateIdle;
      oe_d    = 1'b0;
    end
  end

  // TX prefetch into the one-entry hold register
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q & ~hold_take;
    otx_req_d    = otx_req_q;
    otx_ack_d    = 1'b0;
    if (itx_resp) begin
      hold_d       = itx_data;
      hold_valid_d = 1'b1;
      otx_req_d    = 1'b0;
      otx_ack_d    = 1'b1;
    end else if (!hold_valid_q && itx_valid) begin
      otx_req_d = 1'b1;
    end
  end

  assign otx_req     = otx_req_q;
  assign otx_ack     = otx_ack_q;
  assign orx_req     = orx_req_q;
  assign orx_data    = orx_data_q;
  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign obusy       = busy_q;
  assign ooverrun    = ovr_q;
  assign ounderrun   = und_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: an SPI master model drives frames, TX/RX FIFO models answer the
// handshakes, and a monitor checks each presented RX byte against a queue of expected bytes.
module tb_spi_slave_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned H = 80;

  logic         iclk = 1'b0;
  logic         irst = 1'b1;
  logic         icontrol_cpol = 1'b0, icontrol_cpha = 1'b0, icontrol_lsb = 1'b0;
  logic         iclear_flags = 1'b0;
  logic         itx_valid = 1'b0, itx_resp = 1'b0, irx_ack = 1'b0;
  logic [W-1:0] itx_data = '0;
  logic         spi_clk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
  logic         otx_req, otx_ack, orx_req, spi_miso, spi_miso_oe, obusy, ooverrun, ounderrun;
  logic [W-1:0] orx_data;

  spi_slave_ctrl #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .iclk(iclk), .irst(irst),
    .icontrol_cpol(icontrol_cpol), .icontrol_cpha(icontrol_cpha), .icontrol_lsb(icontrol_lsb),
    .iclear_flags(iclear_flags),
    .itx_valid(itx_valid), .otx_req(otx_req), .itx_data(itx_data), .itx_resp(itx_resp),
    .otx_ack(otx_ack),
    .orx_req(orx_req), .orx_data(orx_data), .irx_ack(irx_ack),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .obusy(obusy), .ooverrun(ooverrun), .ounderrun(ounderrun)
  );

  always #5 iclk = ~iclk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] tx_q[$];
  logic [W-1:0] exp_rx[$];
  bit           hold_ack = 1'b0;
  bit           rx_seen = 1'b0;
  int           ack_cnt = 0;
  int           req_cycles = 0;
  int           rx_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // TX FIFO model: one response per request, popped on the acknowledge
  always @(negedge iclk) begin
    if (irst) begin
      itx_resp = 1'b0;
    end else begin
      if (otx_ack) begin
        ack_cnt++;
        if (tx_q.size() > 0) tx_q.delete(0);
      end
      if (otx_req) req_cycles++;
      if (itx_resp) itx_resp = 1'b0;
      else if (otx_req && tx_q.size() > 0) begin
        itx_data = tx_q[0];
        itx_resp = 1'b1;
      end
    end
    itx_valid = (tx_q.size() > 0);
  end

  // RX monitor: checks each new byte once, acknowledges unless held off
  always @(negedge iclk) begin
    if (irst) begin
      rx_seen = 1'b0;
      irx_ack = 1'b0;
    end else if (orx_req) begin
      if (!rx_seen) begin
        rx_cnt++;
        if (exp_rx.size() > 0) chk("rx_data", 32'(orx_data), 32'(exp_rx.pop_front()));
        else begin
          n_checks++;
          n_errors++;
          $display("FAIL rx_unexpected: got 0x%0h expected no byte", orx_data);
        end
      end
      rx_seen = 1'b1;
      irx_ack = !hold_ack;
    end else begin
      rx_seen = 1'b0;
      irx_ack = 1'b0;
    end
  end

  task automatic cs_low(input logic cpol, input logic cpha, input logic lsb);
    icontrol_cpol = cpol;
    icontrol_cpha = cpha;
    icontrol_lsb  = lsb;
    spi_clk       = cpol;
    #(H);
    spi_cs_n = 1'b0;
    #(H);
  endtask

  task automatic cs_high();
    #(H);
    spi_cs_n = 1'b1;
    #(4 * H);
  endtask

  task automatic xfer(input logic cpol, input logic cpha, input logic lsb,
                      input logic [W-1:0] tx, input int nbits, output logic [W-1:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsb ? i : W - 1 - i;
      if (!cpha) begin
        spi_mosi = tx[idx];
        #(H);
        spi_clk = ~cpol;
        rx[idx] = spi_miso;
        #(H);
        spi_clk = cpol;
      end else begin
        spi_clk  = ~cpol;
        spi_mosi = tx[idx];
        #(H);
        spi_clk = cpol;
        rx[idx] = spi_miso;
        #(H);
      end
    end
  endtask

  task automatic run_frame(input string name, input logic cpol, input logic cpha,
                           input logic lsb, input logic [W-1:0] tx, output logic [W-1:0] rx);
    cs_low(cpol, cpha, lsb);
    chk({name, "_oe_on"}, 32'(spi_miso_oe), 1);
    chk({name, "_busy"}, 32'(obusy), 1);
    xfer(cpol, cpha, lsb, tx, W, rx);
    cs_high();
    chk({name, "_oe_off"}, 32'(spi_miso_oe), 0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_rx.size() > 0; i++) @(negedge iclk);
    chk(name, 32'(exp_rx.size()), 0);
  endtask

  task automatic pulse_clear();
    @(negedge iclk);
    iclear_flags = 1'b1;
    @(negedge iclk);
    iclear_flags = 1'b0;
    @(negedge iclk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rx;
    int           base;
    repeat (3) @(negedge iclk);
    chk("reset_outputs", 32'({otx_req, otx_ack, orx_req, orx_data, spi_miso, spi_miso_oe,
                              obusy, ooverrun, ounderrun}), 0);
    irst = 1'b0;
    repeat (10) @(negedge iclk);
    chk("idle_busy", 32'(obusy), 0);

    // Mode 0, MSB first
    tx_q.push_back(8'h3C);
    repeat (10) @(negedge iclk);
    chk("t1_prefetch_ack", 32'(ack_cnt), 1);
    chk("t1_req_dropped", 32'(otx_req), 0);
    exp_rx.push_back(8'hA5);
    run_frame("t1", 1'b0, 1'b0, 1'b0, 8'hA5, rx);
    chk("t1_miso", 32'(rx), 32'h3C);
    drain("t1_rx_drain");
    chk("t1_rx_count", 32'(rx_cnt), 1);
    chk("t1_tx_acks", 32'(ack_cnt), 1);

    // Mode 3, LSB first
    tx_q.push_back(8'h5A);
    repeat (10) @(negedge iclk);
    exp_rx.push_back(8'h81);
    run_frame("t2", 1'b1, 1'b1, 1'b1, 8'h81, rx);
    chk("t2_miso", 32'(rx), 32'h5A);
    drain("t2_rx_drain");

    // Back-to-back frames with the RX FIFO refusing the first byte
    hold_ack = 1'b1;
    exp_rx.push_back(8'h11);
    cs_low(1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 1'b0, 8'h11, W, rx);
    xfer(1'b0, 1'b0, 1'b0, 8'h22, W, rx);
    cs_high();
    drain("t3_rx_drain");
    chk("t3_overrun", 32'(ooverrun), 1);
    chk("t3_req_held", 32'(orx_req), 1);
    chk("t3_data_held", 32'(orx_data), 32'h11);
    pulse_clear();
    chk("t3_overrun_cleared", 32'(ooverrun), 0);
    hold_ack = 1'b0;
    repeat (10) @(negedge iclk);
    chk("t3_req_released", 32'(orx_req), 0);

    // Empty TX FIFO
    pulse_clear();
    chk("t4_underrun_cleared", 32'(ounderrun), 0);
    req_cycles = 0;
    exp_rx.push_back(8'h96);
    run_frame("t4", 1'b0, 1'b0, 1'b0, 8'h96, rx);
    chk("t4_miso", 32'(rx), 0);
    chk("t4_underrun", 32'(ounderrun), 1);
    chk("t4_no_tx_req", 32'(req_cycles), 0);
    drain("t4_rx_drain");

    // Frame aborted after 5 bits, then a full frame
    base = rx_cnt;
    cs_low(1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 1'b0, 8'hFF, 5, rx);
    cs_high();
    chk("t5_no_rx", 32'(rx_cnt - base), 0);
    chk("t5_overrun", 32'(ooverrun), 0);
    chk("t5_oe", 32'(spi_miso_oe), 0);
    exp_rx.push_back(8'hC3);
    run_frame("t5", 1'b0, 1'b0, 1'b0, 8'hC3, rx);
    drain("t5_rx_drain");

    // Reset in the middle of a frame
    cs_low(1'b0, 1'b0, 1'b0);
    xfer(1'b0, 1'b0, 1'b0, 8'h55, 4, rx);
    @(negedge iclk);
    irst = 1'b1;
    @(negedge iclk);
    chk("t6_reset_outputs", 32'({otx_req, otx_ack, orx_req, orx_data, spi_miso, spi_miso_oe,
                                 obusy, ooverrun, ounderrun}), 0);
    irst = 1'b0;
    base = rx_cnt;
    cs_high();
    chk("t6_no_rx", 32'(rx_cnt - base), 0);
    exp_rx.push_back(8'h7E);
    run_frame("t6", 1'b0, 1'b0, 1'b0, 8'h7E, rx);
    drain("t6_rx_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

SPI slave-side controller: the far end of the team's SPI master controller. Oversamples external SPI pins in the iclk domain, deserialises MOSI bytes into an RX FIFO write port and serialises bytes pulled from a TX FIFO read port onto MISO. Uses the same `spi_fifo` req/resp/ack handshakes, so it bolts onto two `spi_fifo` instances exactly as the master controller does.

## Interface
- DATA_WIDTH, 8, bits per SPI frame (byte).
- SYNC_STAGES, 2, flip-flop stages on each incoming SPI pin (≥2).

- iclk  in  1  system clock; must be ≥ 8× SPI clock frequency.
- irst  in  1  reset; synchronous, active-high, on clock iclk.
- icontrol_cpol  in  1  SPI clock idle level; latched on CS_n falling.
- icontrol_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on CS_n falling.
- icontrol_lsb  in  1  1: LSB first; 0: MSB first; latched on CS_n falling.
- iclear_flags  in  1  1-cycle pulse; clears ooverrun/ounderrun.
- itx_valid  in  1  TX FIFO holds data.
- otx_req  out  1  read request to TX FIFO.
- itx_data  in  DATA_WIDTH  TX FIFO read data.
- itx_resp  in  1  TX FIFO data valid.
- otx_ack  out  1  1-cycle pop acknowledge to TX FIFO.
- orx_req  out  1  write request to RX FIFO.
- orx_data  out  DATA_WIDTH  received byte.
- irx_ack  in  1  RX FIFO write accepted.
- spi_clk  in  1  external SPI clock.
- spi_cs_n  in  1  external chip select, active-low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable (high only while selected).
- obusy  out  1  CS_n (synchronised) low.
- ooverrun  out  1  sticky: received byte dropped.
- ounderrun  out  1  sticky: byte transmitted without TX data.

## Operation
- Pins pass through SYNC_STAGES flops; edges of the synchronised clock and CS_n are detected against a one-cycle-delayed copy.
- Leading edge = rising if cpol=0, falling if cpol=1. Sample edge = leading if cpha=0 else trailing; shift edge = the other one.
- Prefetch engine (independent of the SPI FSM), one-entry hold register with hold_valid:
  - hold_valid=0 and itx_valid=1: assert otx_req.
  - On itx_resp: capture itx_data into hold; set hold_valid; drop otx_req; pulse otx_ack next cycle.
- SPI FSM states:
  - StateIdle: spi_miso_oe=0. CS_n fall → latch cpol/cpha/lsb → StateLoad.
  - StateLoad, 1 cycle: load the shift register from hold (clear hold_valid), or all-zeros with ounderrun=1 if hold is empty. Clear the bit counter. For cpha=0, drive the first bit on MISO. → StateShift.
  - StateShift:
    - Sample edge: shift MOSI into the rx shifter; increment the counter.
    - Shift edge: drive the next TX bit. With cpha=1, the first leading edge drives bit 0 of the frame.
    - When the counter reaches DATA_WIDTH → StatePush.
  - StatePush, 1 cycle: if orx_req=0, copy the rx shifter to orx_data and set orx_req; else set ooverrun and drop the byte. → StateLoad (back-to-back frame).
- orx_req stays high until irx_ack; it is cleared in the cycle irx_ack is seen, and that clearing is independent of the FSM.
- Bit order: lsb=1 shifts/serialises bit 0 first, else bit DATA_WIDTH-1 first.
- CS_n rise in any state → StateIdle, spi_miso_oe=0. A partial rx byte is discarded without a flag. A TX byte already loaded is consumed.
- iclear_flags and a simultaneous set: set wins.

## Timing
- Reset values: otx_req=0, otx_ack=0, orx_req=0, orx_data=0, spi_miso=0, spi_miso_oe=0, obusy=0, ooverrun=0, ounderrun=0, hold_valid=0, FSM=StateIdle.
- irst mid-frame: everything returns to reset values the next cycle. The SPI transaction is abandoned; a new frame requires a fresh CS_n fall.
- Pin edge → internal edge detect: SYNC_STAGES+1 iclk. MISO update: +1 iclk after shift-edge detect (≤ SYNC_STAGES+2 total, within a half SPI period at 8×).
- CS_n fall → spi_miso_oe=1 and first bit valid: SYNC_STAGES+3 iclk.
- Final sample edge detect → orx_req high: 2 iclk.
- Prefetch: itx_valid → otx_req 1 cycle later; otx_ack exactly one cycle wide, the cycle after itx_resp.
- Push and load for consecutive frames take 2 iclk total; both complete before the next shift edge at ≥8× ratio.

## Test plan
- Mode 0, MSB first: TX FIFO preloaded 0x3C, master sends 0xA5 → orx_data=0xA5 with one orx_req/irx_ack, MISO bits 0,0,1,1,1,1,0,0, one otx_ack.
- Mode 3 (cpol=1, cpha=1), LSB first: master sends 0x81, slave TX 0x5A → orx_data=0x81, master receives 0x5A.
- Two back-to-back frames 0x11, 0x22 with irx_ack withheld → first orx_data=0x11 held, ooverrun=1, 0x22 dropped; iclear_flags → ooverrun=0.
- TX FIFO empty (itx_valid=0), one frame → MISO all zeros, ounderrun=1, otx_req never asserted.
- CS_n raised after 5 bits → no orx_req, ooverrun=0, FSM Idle, spi_miso_oe=0; the next full frame 0xC3 is received correctly.
- irst asserted at bit 4 → all outputs at reset values next cycle; post-reset frame 0x7E is received correctly.
